mac_unit: RTL

Signed multiply-accumulate stage directly downstream of the input buffer in the CIFAR-10 convolution datapath. Consumes one `vector`-long activation stream (one byte per beat, as the buffer's serial output delivers it) paired with a weight stream. Adds a bias, requantizes by an arithmetic right shift with rounding, and applies optional ReLU and 8-bit saturation. Emits one 8-bit result per dot product with a one-cycle valid strobe.

---
 rtl/mac_unit_pkg.sv | 23 ++
 rtl/mac_unit_requant.sv | 52 +++++
 rtl/mac_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mac_unit_pkg.sv
// rtl/mac_unit_pkg.sv - shared constants and state encoding for the convolution MAC stage
//
// Holds the default activation width and vector length that the input
// buffer, this stage and the sequencer must agree on. It also holds the
// MAC controller state encoding.
package mac_unit_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_VECTOR    = 4;
    localparam int DEF_ACC_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        POST = 2'd2
    } mac_state_e;

    // A counter is at least one bit wide, so that a vector length of 1 still elaborates.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_unit_requant.sv
// rtl/mac_unit_requant.sv - combinational round/shift/ReLU/saturate of the accumulator
//
// Ports:
//   i_acc     : signed accumulator value, ACC_WIDTH bits
//   i_shift   : arithmetic right shift 0..15, round-half-up when non-zero
//   i_relu_en : clamp negative results to zero
//   o_out     : signed WIDTH-bit result
//   o_sat     : result was clipped to the WIDTH-bit range
module mac_unit_requant #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic        [3:0]           i_shift,
    input  logic                        i_relu_en,
    output logic signed [WIDTH-1:0]     o_out,
    output logic                        o_sat
);

    // One guard bit so the rounding add cannot wrap at the top of the range.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] ONE =
        {{ACC_WIDTH{1'b0}}, 1'b1};

    logic signed [ACC_WIDTH:0] w_acc_ext;
    logic signed [ACC_WIDTH:0] w_half;
    logic signed [ACC_WIDTH:0] w_sum;
    logic signed [ACC_WIDTH:0] w_shifted;
    logic signed [ACC_WIDTH:0] w_relu;

    assign w_acc_ext = {i_acc[ACC_WIDTH-1], i_acc};
    assign w_half    = (i_shift == 4'd0) ? '0 : (ONE << (i_shift - 4'd1));
    assign w_sum     = w_acc_ext + w_half;
    assign w_shifted = w_sum >>> i_shift;
    assign w_relu    = (i_relu_en && w_shifted[ACC_WIDTH]) ? '0 : w_shifted;

    always_comb begin
        o_out = w_relu[WIDTH-1:0];
        o_sat = 1'b0;
        if (w_relu > SAT_MAX) begin
            o_out = SAT_MAX[WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_relu < SAT_MIN) begin
            o_out = SAT_MIN[WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate stage with bias, requantize, ReLU and saturation
//
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_start        : begin a dot product (honoured only in IDLE); samples bias/shift/relu
//   i_clr          : synchronous abort to IDLE, no result produced
//   i_in_valid     : i_in/i_w carry a beat this cycle
//   i_in, i_w      : signed activation and weight
//   i_bias         : signed 16-bit bias
//   i_shift        : requantize shift 0..15
//   i_relu_en      : clamp negative results to zero
//   o_out          : signed result, held until the next result
//   o_out_valid    : one-cycle strobe marking a new o_out
//   o_sat          : o_out was clipped to range
//   o_busy         : high while accumulating or post-processing
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int VECTOR    = DEF_VECTOR,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_clr,
    input  logic                    i_in_valid,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] i_w,
    input  logic signed [15:0]      i_bias,
    input  logic        [3:0]       i_shift,
    input  logic                    i_relu_en,
    output logic signed [WIDTH-1:0] o_out,
    output logic                    o_out_valid,
    output logic                    o_sat,
    output logic                    o_busy
);

    localparam int CNT_W = cnt_bits(VECTOR);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR - 1);

    mac_state_e r_state;
    mac_state_e w_state_next;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [CNT_W-1:0]     r_cnt;
    logic        [3:0]           r_shift;
    logic                        r_relu_en;

    logic                        w_load;
    logic                        w_beat;
    logic                        w_emit;

    logic signed [2*WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [WIDTH-1:0]     w_rq_out;
    logic                        w_rq_sat;

    assign w_prod     = i_in * i_w;
    assign w_prod_ext = {{(ACC_WIDTH-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_WIDTH-16){i_bias[15]}}, i_bias};

    assign o_busy = (r_state != IDLE);

    mac_unit_requant #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_requant (
        .i_acc     (r_acc),
        .i_shift   (r_shift),
        .i_relu_en (r_relu_en),
        .o_out     (w_rq_out),
        .o_sat     (w_rq_sat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear overrides every action, so the load, beat and emit strobes are all gated by i_clr.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_beat       = 1'b0;
        w_emit       = 1'b0;
        if (i_clr) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_load       = 1'b1;
                        w_state_next = ACC;
                    end
                end
                ACC: begin
                    if (i_in_valid) begin
                        w_beat = 1'b1;
                        if (r_cnt == LAST_BEAT) begin
                            w_state_next = POST;
                        end
                    end
                end
                POST: begin
                    w_emit       = 1'b1;
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_relu_en   <= 1'b0;
            o_out       <= '0;
            o_out_valid <= 1'b0;
            o_sat       <= 1'b0;
        end else begin
            o_out_valid <= w_emit;
            if (w_load) begin
                r_acc     <= w_bias_ext;
                r_cnt     <= '0;
                r_shift   <= i_shift;
                r_relu_en <= i_relu_en;
            end
            if (w_beat) begin
                r_acc <= r_acc + w_prod_ext;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_emit) begin
                o_out <= w_rq_out;
                o_sat <= w_rq_sat;
            end
        end
    end

endmodule
